// File: rtl/mw_stage_reg_if.sv
// M->W bus: M-stage instruction fields in, W-stage regfile write port out.
// master drives m_* and observes w_*; slave is the stage register.
interface mw_stage_reg_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_alu;
  logic [31:0] m_dm_rd;
  logic [4:0]  m_rd_addr;
  logic        m_reg_we;
  logic [1:0]  m_wdsel;
  logic [2:0]  m_ld_type;

  logic        w_valid;
  logic [31:0] w_pc;
  logic [4:0]  w_rd_addr;
  logic        w_reg_we;
  logic [31:0] w_wd;

  modport master (
    output m_valid, m_pc, m_alu, m_dm_rd,
    output m_rd_addr, m_reg_we, m_wdsel, m_ld_type,
    input  w_valid, w_pc, w_rd_addr, w_reg_we, w_wd
  );

  modport slave (
    input  m_valid, m_pc, m_alu, m_dm_rd,
    input  m_rd_addr, m_reg_we, m_wdsel, m_ld_type,
    output w_valid, w_pc, w_rd_addr, w_reg_we, w_wd
  );
endinterface

// File: rtl/mw_stage_reg.sv
// M->W pipeline register with load extension and writeback select.
// Ports: clk, reset (sync, high), stall, flush, bus (slave), retire_cnt.
module mw_stage_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  mw_stage_reg_if.slave bus,
  output logic [31:0] retire_cnt
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dm_rd;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic [1:0]  wdsel;
    logic [2:0]  ld_type;
  } w_t;

  w_t          w_d, w_q;
  logic [31:0] cnt_d, cnt_q;
  w_t          m_in;

  always_comb begin
    m_in.valid   = bus.m_valid;
    m_in.pc      = bus.m_pc;
    m_in.alu     = bus.m_alu;
    m_in.dm_rd   = bus.m_dm_rd;
    m_in.rd_addr = bus.m_rd_addr;
    m_in.reg_we  = bus.m_reg_we;
    m_in.wdsel   = bus.m_wdsel;
    m_in.ld_type = bus.m_ld_type;
  end

  // The instruction leaves W whenever the slot is not held,
  // including when a flush replaces it with a bubble.
  always_comb begin
    w_d   = w_q;
    cnt_d = cnt_q;
    if (reset) begin
      w_d   = '0;
      cnt_d = '0;
    end else if (flush) begin
      w_d   = '0;
      cnt_d = cnt_q + {31'd0, w_q.valid};
    end else if (!stall) begin
      w_d   = m_in;
      cnt_d = cnt_q + {31'd0, w_q.valid};
    end
  end

  always_ff @(posedge clk) begin
    w_q   <= w_d;
    cnt_q <= cnt_d;
  end

  logic [1:0]  off;
  logic [15:0] half;
  logic [7:0]  byte_v;
  logic [31:0] ld_ext;

  assign off = w_q.alu[1:0];

  always_comb begin
    half   = off[1] ? w_q.dm_rd[31:16] : w_q.dm_rd[15:0];
    byte_v = w_q.dm_rd[7:0];
    case (off)
      2'd1:    byte_v = w_q.dm_rd[15:8];
      2'd2:    byte_v = w_q.dm_rd[23:16];
      2'd3:    byte_v = w_q.dm_rd[31:24];
      default: byte_v = w_q.dm_rd[7:0];
    endcase
  end

  always_comb begin
    case (w_q.ld_type)
      3'd1:    ld_ext = {{16{half[15]}}, half};
      3'd2:    ld_ext = {16'd0, half};
      3'd3:    ld_ext = {{24{byte_v[7]}}, byte_v};
      3'd4:    ld_ext = {24'd0, byte_v};
      default: ld_ext = w_q.dm_rd;
    endcase
  end

  always_comb begin
    case (w_q.wdsel)
      2'd1:    bus.w_wd = ld_ext;
      2'd2:    bus.w_wd = w_q.pc + 32'd8;
      default: bus.w_wd = w_q.alu;
    endcase
  end

  assign bus.w_valid   = w_q.valid;
  assign bus.w_pc      = w_q.pc;
  assign bus.w_rd_addr = w_q.rd_addr;
  assign bus.w_reg_we  = w_q.valid & w_q.reg_we & (w_q.rd_addr != 5'd0);
  assign retire_cnt    = cnt_q;

endmodule

// File: tb/tb_mw_stage_reg.sv
// Directed bench for mw_stage_reg with a transaction-level reference
// model checked every cycle plus literal expectations.
module tb_mw_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] retire_cnt;

  mw_stage_reg_if bus();

  mw_stage_reg dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference: the instruction sitting in W, as plain values.
  typedef struct {
    bit          valid;
    bit [31:0]   pc, alu, dm, cnt_dummy;
    bit [4:0]    rd;
    bit          we;
    int unsigned sel, ld;
  } instr_t;

  instr_t      slot;
  bit [31:0]   m_cnt;
  bit          started = 0;

  function automatic bit [31:0] model_wd(input instr_t i);
    int unsigned off, h, b;
    bit [31:0]   r;
    off = i.alu % 4;
    if (i.sel == 2) return i.pc + 32'd8;
    if (i.sel != 1) return i.alu;
    case (i.ld)
      1, 2: begin
        h = (i.dm >> (off >= 2 ? 16 : 0)) & 32'hFFFF;
        r = h;
        if (i.ld == 1 && h >= 32'h8000) r = h + 32'hFFFF_0000;
        return r;
      end
      3, 4: begin
        b = (i.dm >> (8 * off)) & 32'hFF;
        r = b;
        if (i.ld == 3 && b >= 32'h80) r = b + 32'hFFFF_FF00;
        return r;
      end
      default: return i.dm;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      slot    = '{default: 0};
      m_cnt   = 0;
      started = 1;
    end else begin
      if ((flush || !stall) && slot.valid) m_cnt = m_cnt + 1;
      if (flush) slot = '{default: 0};
      else if (!stall) begin
        slot.valid = bus.m_valid;
        slot.pc    = bus.m_pc;
        slot.alu   = bus.m_alu;
        slot.dm    = bus.m_dm_rd;
        slot.rd    = bus.m_rd_addr;
        slot.we    = bus.m_reg_we;
        slot.sel   = bus.m_wdsel;
        slot.ld    = bus.m_ld_type;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("w_valid", {31'd0, bus.w_valid}, {31'd0, slot.valid});
      check("w_pc", bus.w_pc, slot.pc);
      check("w_rd_addr", {27'd0, bus.w_rd_addr}, {27'd0, slot.rd});
      check("w_reg_we", {31'd0, bus.w_reg_we},
            {31'd0, slot.valid && slot.we && slot.rd != 0});
      check("w_wd", bus.w_wd, model_wd(slot));
      check("retire_cnt", retire_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [2:0] ld);
    bus.m_valid   = v;
    bus.m_pc      = pc;
    bus.m_alu     = alu;
    bus.m_dm_rd   = dm;
    bus.m_rd_addr = rd;
    bus.m_reg_we  = we;
    bus.m_wdsel   = sel;
    bus.m_ld_type = ld;
  endtask

  localparam logic [31:0] DM = 32'h8081_F27F;
  logic [31:0] c0;

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, $urandom, $urandom, 5'($urandom),
            1'b1, 2'($urandom), 3'($urandom));
      tick();
    end
    check("rst_valid", {31'd0, bus.w_valid}, 32'd0);
    check("rst_wd", bus.w_wd, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    reset = 1'b0;

    drive(1, 32'h100, 32'h200, DM, 8, 1, 1, 3); tick();
    check("lb0", bus.w_wd, 32'h0000_007F);
    drive(1, 32'h104, 32'h201, DM, 8, 1, 1, 3); tick();
    check("lb1", bus.w_wd, 32'hFFFF_FFF2);
    drive(1, 32'h108, 32'h203, DM, 8, 1, 1, 4); tick();
    check("lbu3", bus.w_wd, 32'h0000_0080);
    drive(1, 32'h10C, 32'h202, DM, 8, 1, 1, 1); tick();
    check("lh2", bus.w_wd, 32'hFFFF_8081);
    drive(1, 32'h110, 32'h200, DM, 8, 1, 1, 2); tick();
    check("lhu0", bus.w_wd, 32'h0000_F27F);
    drive(1, 32'h114, 32'h202, DM, 8, 1, 1, 0); tick();
    check("lw2", bus.w_wd, 32'h8081_F27F);
    drive(1, 32'h118, 32'h201, DM, 8, 1, 1, 7); tick();
    check("ld7", bus.w_wd, 32'h8081_F27F);
    drive(1, 32'h11C, 32'hCAFE_0001, DM, 9, 1, 3, 0); tick();
    check("sel3", bus.w_wd, 32'hCAFE_0001);

    drive(1, 32'h3004, 32'h0, 32'h0, 31, 1, 2, 0); tick();
    check("jal_wd", bus.w_wd, 32'h0000_300C);
    check("jal_we", {31'd0, bus.w_reg_we}, 32'd1);
    drive(1, 32'h3004, 32'h0, 32'h0, 0, 1, 2, 0); tick();
    check("r0_we", {31'd0, bus.w_reg_we}, 32'd0);
    drive(1, 32'hFFFF_FFFC, 32'h0, 32'h0, 3, 1, 2, 0); tick();
    check("pc8_wrap", bus.w_wd, 32'h0000_0004);

    drive(1, 32'h3000, 32'h11, 32'h0, 4, 1, 0, 0); tick();
    c0 = retire_cnt;
    stall = 1'b1;
    drive(1, 32'h4000, 32'h22, 32'h0, 5, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.w_pc, 32'h3000);
    end
    check("stall_cnt", retire_cnt, c0);
    stall = 1'b0;
    tick();
    check("after_stall_pc", bus.w_pc, 32'h4000);
    check("after_stall_cnt", retire_cnt, c0 + 32'd1);

    c0 = retire_cnt;
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    check("flush_valid", {31'd0, bus.w_valid}, 32'd0);
    check("flush_we", {31'd0, bus.w_reg_we}, 32'd0);
    check("flush_cnt", retire_cnt, c0 + 32'd1);

    c0 = retire_cnt;
    for (int i = 0; i < 6; i++) begin
      drive(i[0], 32'h5000 + 32'(4 * i), 32'(i), 32'h0, 6, 1, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("bubble_cnt", retire_cnt, c0 + 32'd3);

    drive(1, 32'h6000, 32'h1, 32'h0, 7, 1, 0, 0); tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    check("midrst_cnt", retire_cnt, 32'd0);
    check("midrst_valid", {31'd0, bus.w_valid}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
